// File: rtl/vc_queue_if.sv
// Handshake bundle for vc_queue: one shared enqueue port carrying a VC id,
// per-VC dequeue strobes/ready/head data, per-VC occupancy and the sticky
// protocol-error flag.
//   master : drives enq_en/enq_vc/enq_msg/deq_en, observes the rest
//   slave  : the queue itself
interface vc_queue_if #(
  parameter int unsigned data_width  = 32,
  parameter int unsigned num_entries = 2,
  parameter int unsigned num_vcs     = 2,
  parameter int unsigned count_width = $clog2(num_entries + 1),
  parameter int unsigned vc_width    = (num_vcs == 1) ? 1 : $clog2(num_vcs)
);
  logic                              enq_en;
  logic [vc_width-1:0]               enq_vc;
  logic [data_width-1:0]             enq_msg;
  logic [num_vcs-1:0]                enq_rdy;
  logic [num_vcs-1:0]                deq_en;
  logic [num_vcs-1:0]                deq_rdy;
  logic [num_vcs*data_width-1:0]     deq_msg;
  logic [num_vcs*count_width-1:0]    count;
  logic                              ovf_err;

  modport master (
    output enq_en, enq_vc, enq_msg, deq_en,
    input  enq_rdy, deq_rdy, deq_msg, count, ovf_err
  );

  modport slave (
    input  enq_en, enq_vc, enq_msg, deq_en,
    output enq_rdy, deq_rdy, deq_msg, count, ovf_err
  );
endinterface

// File: rtl/vc_queue.sv
// Multi-VC register FIFO for router input ports. num_vcs independent circular
// buffers of num_entries words, one shared enqueue port (with VC id) and
// per-VC dequeue. mode: 0 normal, 1 pipe (full VC accepts while dequeued),
// 2 bypass (empty VC forwards enq_msg combinationally). ovf_err is sticky
// until reset.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   q     : vc_queue_if slave (enq_en/enq_vc/enq_msg/enq_rdy, deq_en/deq_rdy/
//           deq_msg, count, ovf_err)
module vc_queue #(
  parameter int unsigned data_width  = 32,
  parameter int unsigned num_entries = 2,
  parameter int unsigned num_vcs     = 2,
  parameter int unsigned mode        = 0,
  parameter int unsigned count_width = $clog2(num_entries + 1),
  parameter int unsigned vc_width    = (num_vcs == 1) ? 1 : $clog2(num_vcs)
) (
  input  logic        clk,
  input  logic        reset,
  vc_queue_if.slave   q
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_PIPE   = 2'd1,
    MODE_BYPASS = 2'd2
  } mode_e;

  localparam int unsigned ptr_width   = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam bit          pipe_mode   = (mode == int'(MODE_PIPE));
  localparam bit          bypass_mode = (mode == int'(MODE_BYPASS));

  logic [data_width-1:0]  mem     [num_vcs][num_entries];
  logic [ptr_width-1:0]   enq_ptr [num_vcs];
  logic [ptr_width-1:0]   deq_ptr [num_vcs];
  logic [count_width-1:0] cnt     [num_vcs];
  logic                   ovf;

  logic [vc_width-1:0] vc_sel;
  logic                vc_ok;
  logic [num_vcs-1:0]  hit, empty, full;
  logic [num_vcs-1:0]  enq_rdy_i, deq_rdy_i;
  logic [num_vcs-1:0]  enq_acc, deq_acc, thru, wr, rd;
  logic                err;

  function automatic logic [ptr_width-1:0] adv(input logic [ptr_width-1:0] p);
    return (32'(p) == num_entries - 1) ? '0 : p + ptr_width'(1);
  endfunction

  always_comb begin
    vc_sel    = q.enq_vc;
    vc_ok     = 32'(vc_sel) < num_vcs;
    hit       = '0;
    empty     = '0;
    full      = '0;
    enq_rdy_i = '0;
    deq_rdy_i = '0;
    enq_acc   = '0;
    deq_acc   = '0;
    thru      = '0;
    wr        = '0;
    rd        = '0;
    for (int unsigned v = 0; v < num_vcs; v++) begin
      hit[v]       = q.enq_en && vc_ok && (32'(vc_sel) == v);
      empty[v]     = (cnt[v] == '0);
      full[v]      = (cnt[v] == count_width'(num_entries));
      enq_rdy_i[v] = !full[v] || (pipe_mode && q.deq_en[v]);
      deq_rdy_i[v] = !empty[v] || (bypass_mode && hit[v]);
      enq_acc[v]   = hit[v] && enq_rdy_i[v];
      deq_acc[v]   = q.deq_en[v] && deq_rdy_i[v];
      // Bypass on an empty VC: the word goes straight out, storage untouched.
      thru[v]      = bypass_mode && empty[v] && enq_acc[v] && deq_acc[v];
      wr[v]        = enq_acc[v] && !thru[v];
      rd[v]        = deq_acc[v] && !thru[v];
    end
    // Any enqueue strobe not accepted (bad VC id or not ready) is an error.
    err = (q.enq_en && !(|enq_acc)) || (|(q.deq_en & ~deq_rdy_i));
  end

  always_comb begin
    q.enq_rdy = enq_rdy_i;
    q.deq_rdy = deq_rdy_i;
    q.ovf_err = ovf;
    q.deq_msg = '0;
    q.count   = '0;
    for (int unsigned v = 0; v < num_vcs; v++) begin
      q.deq_msg[v*data_width +: data_width] =
        (bypass_mode && empty[v]) ? q.enq_msg : mem[v][deq_ptr[v]];
      q.count[v*count_width +: count_width] = cnt[v];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      for (int unsigned v = 0; v < num_vcs; v++) begin
        enq_ptr[v] <= '0;
        deq_ptr[v] <= '0;
        cnt[v]     <= '0;
      end
    end else begin
      if (err) ovf <= 1'b1;
      for (int unsigned v = 0; v < num_vcs; v++) begin
        if (wr[v]) enq_ptr[v] <= adv(enq_ptr[v]);
        if (rd[v]) deq_ptr[v] <= adv(deq_ptr[v]);
        if (wr[v] && !rd[v])      cnt[v] <= cnt[v] + count_width'(1);
        else if (rd[v] && !wr[v]) cnt[v] <= cnt[v] - count_width'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < num_vcs; v++) begin
      if (wr[v]) mem[v][enq_ptr[v]] <= q.enq_msg;
    end
  end

endmodule

// File: tb/tb_vc_queue.sv
// Bench for vc_queue: four instances (normal/pipe/bypass with 2 VCs, normal
// with 3 VCs) share one stimulus stream. A queue-per-VC reference model
// predicts every output each cycle; directed tables and short sequences
// cover the overflow, wrap, pipe, bypass and mid-operation reset cases.
module tb_vc_queue;

  localparam int NE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_en;
  logic [1:0] enq_vc;
  logic [7:0] enq_msg;
  logic [2:0] deq_en;

  always #5 clk = ~clk;

  vc_queue_if #(.data_width(8), .num_entries(3), .num_vcs(2)) if0 ();
  vc_queue_if #(.data_width(8), .num_entries(3), .num_vcs(2)) if1 ();
  vc_queue_if #(.data_width(8), .num_entries(3), .num_vcs(2)) if2 ();
  vc_queue_if #(.data_width(8), .num_entries(3), .num_vcs(3)) if3 ();

  assign if0.enq_en = enq_en; assign if0.enq_vc = enq_vc[0];
  assign if0.enq_msg = enq_msg; assign if0.deq_en = deq_en[1:0];
  assign if1.enq_en = enq_en; assign if1.enq_vc = enq_vc[0];
  assign if1.enq_msg = enq_msg; assign if1.deq_en = deq_en[1:0];
  assign if2.enq_en = enq_en; assign if2.enq_vc = enq_vc[0];
  assign if2.enq_msg = enq_msg; assign if2.deq_en = deq_en[1:0];
  assign if3.enq_en = enq_en; assign if3.enq_vc = enq_vc;
  assign if3.enq_msg = enq_msg; assign if3.deq_en = deq_en;

  vc_queue #(.data_width(8), .num_entries(3), .num_vcs(2), .mode(0))
    dut0 (.clk(clk), .reset(reset), .q(if0));
  vc_queue #(.data_width(8), .num_entries(3), .num_vcs(2), .mode(1))
    dut1 (.clk(clk), .reset(reset), .q(if1));
  vc_queue #(.data_width(8), .num_entries(3), .num_vcs(2), .mode(2))
    dut2 (.clk(clk), .reset(reset), .q(if2));
  vc_queue #(.data_width(8), .num_entries(3), .num_vcs(3), .mode(0))
    dut3 (.clk(clk), .reset(reset), .q(if3));

  logic [2:0]  o_enq_rdy [4];
  logic [2:0]  o_deq_rdy [4];
  logic [23:0] o_msg     [4];
  logic [5:0]  o_cnt     [4];
  logic        o_ovf     [4];

  assign o_enq_rdy[0] = {1'b0, if0.enq_rdy}; assign o_deq_rdy[0] = {1'b0, if0.deq_rdy};
  assign o_msg[0] = {8'h0, if0.deq_msg};     assign o_cnt[0] = {2'b0, if0.count};
  assign o_ovf[0] = if0.ovf_err;
  assign o_enq_rdy[1] = {1'b0, if1.enq_rdy}; assign o_deq_rdy[1] = {1'b0, if1.deq_rdy};
  assign o_msg[1] = {8'h0, if1.deq_msg};     assign o_cnt[1] = {2'b0, if1.count};
  assign o_ovf[1] = if1.ovf_err;
  assign o_enq_rdy[2] = {1'b0, if2.enq_rdy}; assign o_deq_rdy[2] = {1'b0, if2.deq_rdy};
  assign o_msg[2] = {8'h0, if2.deq_msg};     assign o_cnt[2] = {2'b0, if2.count};
  assign o_ovf[2] = if2.ovf_err;
  assign o_enq_rdy[3] = if3.enq_rdy;         assign o_deq_rdy[3] = if3.deq_rdy;
  assign o_msg[3] = if3.deq_msg;             assign o_cnt[3] = if3.count;
  assign o_ovf[3] = if3.ovf_err;

  // ---------------- reference model ----------------
  int unsigned nvs   [4] = '{2, 2, 2, 3};
  int unsigned modes [4] = '{0, 1, 2, 0};
  logic [7:0]  mq [4][3][$];
  bit          m_ovf [4];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned ev(input int d);
    return (nvs[d] == 2) ? 32'(enq_vc[0]) : 32'(enq_vc);
  endfunction

  function automatic bit m_enq_rdy(input int d, input int unsigned v);
    return (mq[d][v].size() < NE) || (modes[d] == 1 && deq_en[v]);
  endfunction

  function automatic bit m_deq_rdy(input int d, input int unsigned v);
    return (mq[d][v].size() > 0) || (modes[d] == 2 && enq_en && ev(d) == v);
  endfunction

  function automatic logic [7:0] m_msg(input int d, input int unsigned v);
    return (mq[d][v].size() > 0) ? mq[d][v][0] : enq_msg;
  endfunction

  task automatic check_model();
    for (int d = 0; d < 4; d++) begin
      for (int unsigned v = 0; v < nvs[d]; v++) begin
        chk($sformatf("d%0d_enq_rdy%0d", d, v), 32'(o_enq_rdy[d][v]), 32'(m_enq_rdy(d, v)));
        chk($sformatf("d%0d_deq_rdy%0d", d, v), 32'(o_deq_rdy[d][v]), 32'(m_deq_rdy(d, v)));
        if (m_deq_rdy(d, v))
          chk($sformatf("d%0d_deq_msg%0d", d, v), 32'(o_msg[d][v*8 +: 8]), 32'(m_msg(d, v)));
        chk($sformatf("d%0d_count%0d", d, v), 32'(o_cnt[d][v*2 +: 2]), mq[d][v].size());
      end
      chk($sformatf("d%0d_ovf", d), 32'(o_ovf[d]), 32'(m_ovf[d]));
    end
  endtask

  // Check outputs against the model, clock one edge, advance the model.
  task automatic cycle();
    bit          ea  [4];
    bit          da  [4][3];
    bit          er  [4];
    int unsigned e   [4];
    #2;
    check_model();
    for (int d = 0; d < 4; d++) begin
      e[d]  = ev(d);
      ea[d] = enq_en && (e[d] < nvs[d]) && m_enq_rdy(d, e[d]);
      er[d] = enq_en && !ea[d];
      for (int unsigned v = 0; v < 3; v++) begin
        da[d][v] = (v < nvs[d]) && deq_en[v] && m_deq_rdy(d, v);
        if (v < nvs[d] && deq_en[v] && !da[d][v]) er[d] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      if (er[d]) m_ovf[d] = 1'b1;
      for (int unsigned v = 0; v < nvs[d]; v++) begin
        if (!(modes[d] == 2 && mq[d][v].size() == 0 && ea[d] && e[d] == v && da[d][v])) begin
          if (da[d][v]) void'(mq[d][v].pop_front());
          if (ea[d] && e[d] == v) mq[d][v].push_back(enq_msg);
        end
      end
    end
  endtask

  // Reset pulse between edges; the queue must be empty before any edge.
  task automatic do_reset();
    enq_en = 1'b0; deq_en = '0; enq_vc = '0; enq_msg = '0;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_d%0d_count", d), 32'(o_cnt[d]), 0);
      chk($sformatf("rst_d%0d_deq_rdy", d), 32'(o_deq_rdy[d]), 0);
      chk($sformatf("rst_d%0d_enq_rdy", d), 32'(o_enq_rdy[d]), (nvs[d] == 3) ? 7 : 3);
      chk($sformatf("rst_d%0d_ovf", d), 32'(o_ovf[d]), 0);
      m_ovf[d] = 1'b0;
      for (int v = 0; v < 3; v++) mq[d][v].delete();
    end
    #1;
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst;
    int         d;
    bit         en;
    logic [1:0] vc;
    logic [7:0] msg;
    logic [2:0] deq;
    logic [1:0] x_enq_rdy;
    logic [1:0] x_deq_rdy;
    int         msg_vc;
    logic [7:0] x_msg;
    logic [1:0] x_c0;
    logic [1:0] x_c1;
    bit         x_ovf;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit rst, int d, bit en, logic [1:0] vc, logic [7:0] msg,
                              logic [2:0] deq, logic [1:0] er, logic [1:0] dr, int mv,
                              logic [7:0] xm, logic [1:0] c0, logic [1:0] c1, bit ov);
    vec_t t;
    t.rst = rst; t.d = d; t.en = en; t.vc = vc; t.msg = msg; t.deq = deq;
    t.x_enq_rdy = er; t.x_deq_rdy = dr; t.msg_vc = mv; t.x_msg = xm;
    t.x_c0 = c0; t.x_c1 = c1; t.x_ovf = ov;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enq_en = 1'b0; enq_vc = '0; enq_msg = '0; deq_en = '0;
    for (int d = 0; d < 4; d++) m_ovf[d] = 1'b0;
    @(posedge clk); #1;
    do_reset();

    //              rst d  en vc  msg    deq     er     dr    mv  xm     c0 c1 ovf
    // normal: fill VC1, overflow, drain in order
    tbl.push_back(mk(1, 0, 1, 1, 8'h0A, 3'b000, 2'b11, 2'b00, -1, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h0B, 3'b000, 2'b11, 2'b10,  1, 8'h0A, 0, 2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h0C, 3'b000, 2'b11, 2'b10,  1, 8'h0A, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h0D, 3'b000, 2'b01, 2'b10,  1, 8'h0A, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b010, 2'b01, 2'b10,  1, 8'h0A, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b010, 2'b11, 2'b10,  1, 8'h0B, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b010, 2'b11, 2'b10,  1, 8'h0C, 0, 0, 1));
    // pipe: full VC0 accepts while dequeued
    tbl.push_back(mk(1, 1, 1, 0, 8'h01, 3'b000, 2'b11, 2'b00, -1, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h02, 3'b000, 2'b11, 2'b01,  0, 8'h01, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h03, 3'b000, 2'b11, 2'b01,  0, 8'h01, 3, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h55, 3'b001, 2'b11, 2'b01,  0, 8'h01, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'b001, 2'b11, 2'b01,  0, 8'h02, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'b001, 2'b11, 2'b01,  0, 8'h03, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'b001, 2'b11, 2'b01,  0, 8'h55, 0, 0, 0));
    // bypass: pass-through on empty VC1, then stored path
    tbl.push_back(mk(1, 2, 1, 1, 8'h77, 3'b010, 2'b11, 2'b10,  1, 8'h77, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 8'h00, 3'b000, 2'b11, 2'b00, -1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 1, 8'h12, 3'b000, 2'b11, 2'b10,  1, 8'h12, 0, 1, 0));
    tbl.push_back(mk(0, 2, 1, 1, 8'h34, 3'b010, 2'b11, 2'b10,  1, 8'h12, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 0, 8'h00, 3'b010, 2'b11, 2'b10,  1, 8'h34, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 8'h00, 3'b001, 2'b11, 2'b00, -1, 8'h00, 0, 0, 1));

    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      if (t.rst) do_reset();
      enq_en = t.en; enq_vc = t.vc; enq_msg = t.msg; deq_en = t.deq;
      #1;
      chk($sformatf("row%0d_enq_rdy", i), 32'(o_enq_rdy[t.d][1:0]), 32'(t.x_enq_rdy));
      chk($sformatf("row%0d_deq_rdy", i), 32'(o_deq_rdy[t.d][1:0]), 32'(t.x_deq_rdy));
      if (t.msg_vc >= 0)
        chk($sformatf("row%0d_deq_msg", i), 32'(o_msg[t.d][t.msg_vc*8 +: 8]), 32'(t.x_msg));
      cycle();
      chk($sformatf("row%0d_count0", i), 32'(o_cnt[t.d][1:0]), 32'(t.x_c0));
      chk($sformatf("row%0d_count1", i), 32'(o_cnt[t.d][3:2]), 32'(t.x_c1));
      chk($sformatf("row%0d_ovf", i), 32'(o_ovf[t.d]), 32'(t.x_ovf));
    end

    // Wrap on depth 3: values 1..10 through VC0 with overlapping enq/deq.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      enq_en = (k < 10); enq_vc = 2'd0; enq_msg = 8'(k + 1);
      deq_en = (k > 0) ? 3'b001 : 3'b000;
      #1;
      if (k > 0) chk($sformatf("wrap_msg%0d", k), 32'(o_msg[0][7:0]), k);
      cycle();
      chk($sformatf("wrap_count%0d", k), 32'(o_cnt[0][1:0]), (k < 10) ? 1 : 0);
    end

    // Out-of-range VC id on the 3-VC instance: error, no state change.
    do_reset();
    enq_en = 1'b1; enq_vc = 2'd3; enq_msg = 8'hEE; deq_en = '0;
    cycle();
    chk("badvc_ovf", 32'(o_ovf[3]), 1);
    chk("badvc_count", 32'(o_cnt[3]), 0);

    // Reset in mid-operation discards data and clears the error flag.
    do_reset();
    enq_en = 1'b0; deq_en = 3'b111;
    cycle();
    deq_en = '0;
    for (int k = 0; k < 6; k++) begin
      enq_en = 1'b1; enq_vc = 2'(k % 3); enq_msg = 8'h40 + 8'(k);
      cycle();
    end
    chk("midrst_pre_ovf", 32'(o_ovf[0]), 1);
    chk("midrst_pre_count", 32'(o_cnt[3]), 32'h2A);
    do_reset();
    enq_en = 1'b1; enq_vc = 2'd0; enq_msg = 8'h09; deq_en = '0;
    cycle();
    enq_en = 1'b0; deq_en = 3'b001;
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("midrst_d%0d_msg", d), 32'(o_msg[d][7:0]), 32'h09);
    cycle();

    // Randomised traffic with changing dequeue pressure and rare resets.
    for (int blk = 0; blk < 30; blk++) begin
      int unsigned dp;
      dp = $urandom_range(1, 9);
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        enq_en  = ($urandom_range(0, 3) != 0);
        enq_vc  = 2'($urandom_range(0, 3));
        enq_msg = 8'($urandom);
        for (int b = 0; b < 3; b++) deq_en[b] = ($urandom_range(0, 9) < dp);
        cycle();
      end
    end

    enq_en = 1'b0; deq_en = '0;
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
